ahb_filter_dma: RTL and testbench

Single-channel AHB-Lite master that streams a sample buffer through the 3-tap FIR accelerator. After a start pulse it programs the coefficients, clears the filter history, then for each sample reads x[i] from memory, writes it to the accelerator, triggers computation, reads y[i] back and stores it to a destination buffer. It sits beside the CPU as a second bus master and is the initiator-side counterpart of the accelerator's AHB-Lite subordinate port.

---
 rtl/ahb_filter_pkg.sv | 21 ++
 rtl/ahb_filter_dma_if.sv | 14 +
 rtl/ahb_lite_single_master.sv | 30 +++
 rtl/ahb_filter_dma.sv | 98 +++++++++
 tb/tb_ahb_filter_dma.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/ahb_filter_pkg.sv
// ahb_filter_pkg: bus encodings, accelerator register map and DMA state type
package ahb_filter_pkg;
  localparam logic [1:0] HTRANS_IDLE = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HSIZE_WORD = 3'b010;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [31:0] OFF_CTRL = 32'h00;
  localparam logic [31:0] OFF_XN = 32'h04;
  localparam logic [31:0] OFF_C0 = 32'h08;
  localparam logic [31:0] OFF_C1 = 32'h0C;
  localparam logic [31:0] OFF_C2 = 32'h10;
  localparam logic [31:0] OFF_YN = 32'h14;
  localparam logic [31:0] CTRL_START = 32'h1;
  localparam logic [31:0] CTRL_CLEAR = 32'h2;
  typedef enum logic [3:0] {
    IDLE, CFG_C0, CFG_C1, CFG_C2, CFG_CLR, RD_X, WR_X, WR_GO, RD_Y, WR_Y, DONE, ERR
  } state_t;
  function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [31:0] idx);
    return base + (idx << 2);
  endfunction
endpackage

// File: rtl/ahb_filter_dma_if.sv
// ahb_filter_dma_if: AHB-Lite signals between the DMA master and the bus fabric
interface ahb_filter_dma_if;
  logic [31:0] HADDR;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic [1:0] HTRANS;
  logic [2:0] HSIZE;
  logic [2:0] HBURST;
  logic HWRITE;
  logic HREADY;
  logic HRESP;
  modport master(output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA, input HRDATA, HREADY, HRESP);
  modport slave(input HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA, output HRDATA, HREADY, HRESP);
endinterface

// File: rtl/ahb_lite_single_master.sv
// ahb_lite_single_master: non-pipelined single transfers; a req pulse is the address phase,
// the data phase then lasts until HREADY and reports either ack or rerr.
module ahb_lite_single_master
  import ahb_filter_pkg::*;
(
  input  logic HCLK,
  input  logic HRESET,
  input  logic req,
  input  logic we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic ack,
  output logic rerr,
  output logic [31:0] rdata,
  ahb_filter_dma_if.master bus
);
  logic dphase;
  assign bus.HTRANS = req ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign bus.HADDR = addr;
  assign bus.HWRITE = we;
  assign bus.HWDATA = wdata;
  assign bus.HSIZE = HSIZE_WORD;
  assign bus.HBURST = HBURST_SINGLE;
  assign ack = dphase & bus.HREADY & ~bus.HRESP;
  assign rerr = dphase & bus.HREADY & bus.HRESP;
  assign rdata = bus.HRDATA;
  always_ff @(posedge HCLK or posedge HRESET)
    if (HRESET) dphase <= 1'b0;
    else dphase <= req | (dphase & ~bus.HREADY);
endmodule

// File: rtl/ahb_filter_dma.sv
// ahb_filter_dma: streams a sample buffer through the 3-tap FIR accelerator,
// one non-pipelined AHB-Lite transfer per step.
module ahb_filter_dma
  import ahb_filter_pkg::*;
#(
  parameter int LEN_W = 16
) (
  input  logic HCLK,
  input  logic HRESET,
  input  logic start,
  input  logic [31:0] cfg_src,
  input  logic [31:0] cfg_dst,
  input  logic [31:0] cfg_acc,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic [31:0] cfg_c0,
  input  logic [31:0] cfg_c1,
  input  logic [31:0] cfg_c2,
  output logic busy,
  output logic done,
  output logic err,
  ahb_filter_dma_if.master bus
);
  state_t state, nxt;
  logic [31:0] src, dst, acc, c1, c2, addr, wdata, rdata, op_addr, op_wd;
  logic [LEN_W-1:0] len, i, i_nxt;
  logic req, we, ack, rerr, op_we, idle, issue;
  ahb_lite_single_master u_mst (
    .HCLK(HCLK), .HRESET(HRESET), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .ack(ack), .rerr(rerr), .rdata(rdata), .bus(bus)
  );
  assign idle = state inside {IDLE, DONE, ERR};
  assign i_nxt = idle ? '0 : (ack && state == WR_Y) ? i + LEN_W'(1) : i;
  assign issue = nxt != state && !(nxt inside {IDLE, DONE, ERR});
  always_comb begin
    nxt = state;
    if (idle) nxt = start ? CFG_C0 : IDLE;
    else if (rerr) nxt = ERR;
    else if (ack)
      case (state)
        CFG_C0: nxt = CFG_C1;
        CFG_C1: nxt = CFG_C2;
        CFG_C2: nxt = CFG_CLR;
        CFG_CLR: nxt = len == '0 ? DONE : RD_X;
        RD_X: nxt = WR_X;
        WR_X: nxt = WR_GO;
        WR_GO: nxt = RD_Y;
        RD_Y: nxt = WR_Y;
        WR_Y: nxt = i == len - LEN_W'(1) ? DONE : RD_X;
        default: nxt = IDLE;
      endcase
  end
  // Read data feeds the following write directly, so wdata doubles as the x/y holding register.
  always_comb begin
    op_we = 1'b1;
    op_addr = acc + OFF_CTRL;
    op_wd = '0;
    case (nxt)
      CFG_C0: begin op_addr = cfg_acc + OFF_C0; op_wd = cfg_c0; end
      CFG_C1: begin op_addr = acc + OFF_C1; op_wd = c1; end
      CFG_C2: begin op_addr = acc + OFF_C2; op_wd = c2; end
      CFG_CLR: op_wd = CTRL_CLEAR;
      RD_X: begin op_we = 1'b0; op_addr = word_addr(src, 32'(i_nxt)); end
      WR_X: begin op_addr = acc + OFF_XN; op_wd = rdata; end
      WR_GO: op_wd = CTRL_START;
      RD_Y: begin op_we = 1'b0; op_addr = acc + OFF_YN; end
      WR_Y: begin op_addr = word_addr(dst, 32'(i_nxt)); op_wd = rdata; end
      default: op_we = 1'b0;
    endcase
  end
  always_ff @(posedge HCLK or posedge HRESET)
    if (HRESET) begin
      state <= IDLE;
      {req, we, busy, done, err} <= '0;
      {addr, wdata, src, dst, acc, c1, c2} <= '0;
      len <= '0;
      i <= '0;
    end else begin
      state <= nxt;
      i <= i_nxt;
      req <= issue;
      busy <= !(nxt inside {IDLE, DONE, ERR});
      done <= !idle && nxt == DONE;
      err <= !idle && nxt == ERR;
      if (issue) begin
        we <= op_we;
        addr <= op_addr;
        wdata <= op_wd;
      end
      if (idle && start) begin
        src <= cfg_src;
        dst <= cfg_dst;
        acc <= cfg_acc;
        len <= cfg_len;
        c1 <= cfg_c1;
        c2 <= cfg_c2;
      end
    end
endmodule

// File: tb/tb_ahb_filter_dma.sv
// tb_ahb_filter_dma: directed runs against a memory + FIR accelerator subordinate model
module tb_ahb_filter_dma;
  localparam logic [31:0] ACC = 32'h8000_0000;
  logic HCLK = 1'b0, HRESET = 1'b0, start = 1'b0;
  logic [31:0] cfg_src = '0, cfg_dst = '0, cfg_acc = '0, cfg_c0 = '0, cfg_c1 = '0, cfg_c2 = '0;
  logic [15:0] cfg_len = '0;
  logic busy, done, err;
  ahb_filter_dma_if bus();
  ahb_filter_dma #(.LEN_W(16)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .start(start), .cfg_src(cfg_src), .cfg_dst(cfg_dst),
    .cfg_acc(cfg_acc), .cfg_len(cfg_len), .cfg_c0(cfg_c0), .cfg_c1(cfg_c1), .cfg_c2(cfg_c2),
    .busy(busy), .done(done), .err(err), .bus(bus)
  );
  always #5 HCLK = ~HCLK;
  // subordinate model: src words at 0x1000, dst words at 0x1100, accelerator at ACC
  logic [31:0] src_mem [64];
  logic [31:0] dst_mem [64];
  logic [31:0] daddr = '0, hrdata = '0, y_reg = '0, xn = '0, x1 = '0, x2 = '0;
  logic [31:0] c0m = '0, c1m = '0, c2m = '0, acc_last_addr = '0, acc_last_data = '0, err_addr = '0;
  logic dact = 1'b0, dwrite = 1'b0, hready = 1'b1, hresp = 1'b0, go_pend = 1'b0;
  bit wait_mode = 1'b0, err_en = 1'b0;
  int wcnt = 0, w_tmp = 0, nonseq_cnt = 0, mem_cnt = 0, acc_wr_cnt = 0, stab_err = 0;
  assign bus.HREADY = hready;
  assign bus.HRESP = hresp;
  assign bus.HRDATA = hrdata;
  always @(posedge HCLK or posedge HRESET)
    if (HRESET) begin
      dact <= 1'b0; hready <= 1'b1; hresp <= 1'b0; wcnt <= 0; go_pend <= 1'b0;
      for (int k = 0; k < 64; k++) dst_mem[k] <= '0;
    end else begin
      go_pend <= 1'b0;
      if (go_pend) begin
        y_reg <= c0m * xn + c1m * x1 + c2m * x2;
        x1 <= xn;
        x2 <= x1;
      end
      if (dact && hready) begin
        dact <= 1'b0;
        hresp <= 1'b0;
        if (!hresp && dwrite) begin
          if (daddr >= ACC) begin
            acc_wr_cnt <= acc_wr_cnt + 1;
            acc_last_addr <= daddr;
            acc_last_data <= bus.HWDATA;
            case (daddr - ACC)
              32'h00: if (bus.HWDATA == 32'h1) go_pend <= 1'b1;
                      else if (bus.HWDATA == 32'h2) begin x1 <= '0; x2 <= '0; y_reg <= '0; end
              32'h04: xn <= bus.HWDATA;
              32'h08: c0m <= bus.HWDATA;
              32'h0C: c1m <= bus.HWDATA;
              32'h10: c2m <= bus.HWDATA;
              default: ;
            endcase
          end else if (daddr >= 32'h1100 && daddr < 32'h1200) dst_mem[daddr[7:2]] <= bus.HWDATA;
        end
      end else if (dact) begin
        if (hresp) hready <= 1'b1;
        else begin
          wcnt <= wcnt - 1;
          hready <= wcnt == 1;
        end
      end
      if (bus.HTRANS == 2'b10 && !dact) begin
        dact <= 1'b1;
        daddr <= bus.HADDR;
        dwrite <= bus.HWRITE;
        nonseq_cnt <= nonseq_cnt + 1;
        if (bus.HADDR < ACC) mem_cnt <= mem_cnt + 1;
        if (err_en && bus.HADDR == err_addr) begin
          hready <= 1'b0;
          hresp <= 1'b1;
        end else begin
          w_tmp = wait_mode ? int'($urandom_range(0, 3)) : 0;
          wcnt <= w_tmp;
          hready <= w_tmp == 0;
        end
      end
    end
  always @(negedge HCLK)
    hrdata <= !dact ? 32'h0 : daddr == ACC + 32'h14 ? y_reg :
              (daddr >= 32'h1000 && daddr < 32'h1100) ? src_mem[daddr[7:2]] :
              (daddr >= 32'h1100 && daddr < 32'h1200) ? dst_mem[daddr[7:2]] : 32'hDEAD_BEEF;
  always @(negedge HCLK)
    if (dact && (bus.HADDR != daddr || bus.HWRITE != dwrite || bus.HTRANS != 2'b00)) stab_err <= stab_err + 1;

  int n_chk = 0, n_fail = 0, n_cyc = 0, snap_ns = 0, snap_mem = 0, snap_acc = 0;
  logic got_done, got_err, first_busy, end_busy;
  logic [1:0] first_trans;
  logic [31:0] first_addr;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic run(input logic [31:0] c0, c1, c2, src, dst, input logic [15:0] len, input bit poke);
    cfg_c0 = c0; cfg_c1 = c1; cfg_c2 = c2; cfg_src = src; cfg_dst = dst; cfg_acc = ACC; cfg_len = len;
    start = 1'b1;
    n_cyc = 0;
    do begin
      @(negedge HCLK);
      n_cyc++;
      start = 1'b0;
      if (n_cyc == 1) begin first_trans = bus.HTRANS; first_addr = bus.HADDR; first_busy = busy; end
      if (poke && (n_cyc == 5 || n_cyc == 20)) begin
        start = 1'b1; cfg_dst = 32'h1100; cfg_len = 16'd1; cfg_c0 = 32'd99; cfg_acc = 32'h0;
      end
      got_done = done; got_err = err; end_busy = busy;
    end while (!done && !err && n_cyc < 400);
  endtask
  initial begin
    src_mem[0] = 32'd10; src_mem[1] = 32'd20; src_mem[2] = 32'd30;
    src_mem[8] = 32'd5; src_mem[9] = 32'd7;
    #1 HRESET = 1'b1;
    repeat (3) @(negedge HCLK);
    chk("rst_htrans", 32'(bus.HTRANS), 32'h0);
    chk("rst_haddr", bus.HADDR, 32'h0);
    chk("rst_hwrite", 32'(bus.HWRITE), 32'h0);
    chk("rst_hwdata", bus.HWDATA, 32'h0);
    chk("rst_hsize", 32'(bus.HSIZE), 32'h2);
    chk("rst_hburst", 32'(bus.HBURST), 32'h0);
    chk("rst_flags", {29'd0, busy, done, err}, 32'h0);
    HRESET = 1'b0;
    repeat (2) @(negedge HCLK);
    // basic zero-wait run
    run(32'd1, 32'd2, 32'd3, 32'h1000, 32'h1100, 16'd3, 1'b0);
    chk("t1_first_htrans", 32'(first_trans), 32'h2);
    chk("t1_first_haddr", first_addr, ACC + 32'h8);
    chk("t1_first_busy", 32'(first_busy), 32'h1);
    chk("t1_cycles", 32'(n_cyc), 32'd39);
    chk("t1_done_err_busy", {29'd0, got_done, got_err, end_busy}, 32'h4);
    chk("t1_dst0", dst_mem[0], 32'd10);
    chk("t1_dst1", dst_mem[1], 32'd40);
    chk("t1_dst2", dst_mem[2], 32'd100);
    @(negedge HCLK);
    chk("t1_done_pulse", 32'(done), 32'h0);
    // random wait states
    wait_mode = 1'b1;
    run(32'd1, 32'd2, 32'd3, 32'h1000, 32'h1140, 16'd3, 1'b0);
    wait_mode = 1'b0;
    chk("t2_done", 32'(got_done), 32'h1);
    chk("t2_dst0", dst_mem[16], 32'd10);
    chk("t2_dst1", dst_mem[17], 32'd40);
    chk("t2_dst2", dst_mem[18], 32'd100);
    chk("t2_stable", 32'(stab_err), 32'd0);
    @(negedge HCLK);
    // zero-length run
    snap_ns = nonseq_cnt; snap_mem = mem_cnt; snap_acc = acc_wr_cnt;
    run(32'd1, 32'd2, 32'd3, 32'h1000, 32'h1100, 16'd0, 1'b0);
    chk("t3_cycles", 32'(n_cyc), 32'd9);
    chk("t3_done", 32'(got_done), 32'h1);
    chk("t3_nonseq", 32'(nonseq_cnt - snap_ns), 32'd4);
    chk("t3_mem", 32'(mem_cnt - snap_mem), 32'd0);
    chk("t3_accwr", 32'(acc_wr_cnt - snap_acc), 32'd4);
    chk("t3_last_addr", acc_last_addr, ACC);
    chk("t3_last_data", acc_last_data, 32'h2);
    @(negedge HCLK);
    // error response on RD_X of sample 1
    err_en = 1'b1; err_addr = 32'h1004;
    snap_ns = nonseq_cnt;
    run(32'd1, 32'd2, 32'd3, 32'h1000, 32'h1180, 16'd3, 1'b0);
    chk("t4_err", 32'(got_err), 32'h1);
    chk("t4_cycles", 32'(n_cyc), 32'd22);
    chk("t4_busy", 32'(end_busy), 32'h0);
    chk("t4_nonseq", 32'(nonseq_cnt - snap_ns), 32'd10);
    repeat (10) @(negedge HCLK);
    err_en = 1'b0;
    chk("t4_err_pulse", 32'(err), 32'h0);
    chk("t4_no_more", 32'(nonseq_cnt - snap_ns), 32'd10);
    chk("t4_dst0", dst_mem[32], 32'd10);
    chk("t4_dst1", dst_mem[33], 32'd0);
    // start pulses while busy, then back-to-back runs
    run(32'd1, 32'd2, 32'd3, 32'h1000, 32'h11C0, 16'd3, 1'b1);
    chk("t5_cycles", 32'(n_cyc), 32'd39);
    chk("t5_dst", {dst_mem[48][7:0], dst_mem[49][7:0], dst_mem[50][7:0]}, {8'd0, 8'd10, 8'd40, 8'd100});
    run(32'd2, 32'd0, 32'd0, 32'h1020, 32'h11D0, 16'd2, 1'b0);
    chk("t5b_cycles", 32'(n_cyc), 32'd29);
    chk("t5b_dst0", dst_mem[52], 32'd10);
    chk("t5b_dst1", dst_mem[53], 32'd14);
    run(32'd1, 32'd1, 32'd1, 32'h1020, 32'h11E0, 16'd2, 1'b0);
    chk("t5c_dst0", dst_mem[56], 32'd5);
    chk("t5c_dst1", dst_mem[57], 32'd12);
    @(negedge HCLK);
    // reset during WR_Y address phase of sample 0
    cfg_c0 = 32'd1; cfg_c1 = 32'd2; cfg_c2 = 32'd3; cfg_src = 32'h1000; cfg_dst = 32'h11F0; cfg_len = 16'd3;
    start = 1'b1;
    repeat (17) begin @(negedge HCLK); start = 1'b0; end
    chk("t6_wry_addr", bus.HADDR, 32'h11F0);
    chk("t6_wry_htrans", {30'd0, bus.HTRANS}, 32'h2);
    HRESET = 1'b1;
    #1;
    chk("t6_rst_htrans", 32'(bus.HTRANS), 32'h0);
    chk("t6_rst_busy", 32'(busy), 32'h0);
    @(negedge HCLK);
    HRESET = 1'b0;
    @(negedge HCLK);
    run(32'd1, 32'd2, 32'd3, 32'h1000, 32'h11F0, 16'd3, 1'b0);
    chk("t6_cycles", 32'(n_cyc), 32'd39);
    chk("t6_dst0", dst_mem[60], 32'd10);
    chk("t6_dst1", dst_mem[61], 32'd40);
    chk("t6_dst2", dst_mem[62], 32'd100);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
